// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared MultDiv encodings and iteration constants
package multdiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  localparam int MULT_ITER = 32;
  localparam int CNT_W     = 6;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth add/subtract followed by an arithmetic right shift
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             q_1_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             q_1_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc_i;
    case ({q_i[0], q_1_i})
      2'b01:   sum = acc_i + m_i;
      2'b10:   sum = acc_i - m_i;
      default: sum = acc_i;
    endcase
    // Shift the whole {acc, q, q_1} register right, replicating the accumulator sign.
    acc_o = {sum[WIDTH], sum[WIDTH:1]};
    q_o   = {sum[0], q_i[WIDTH-1:1]};
    q_1_o = q_i[0];
  end

endmodule

// File: rtl/booth_mult32.sv
// rtl/booth_mult32.sv - iterative signed 32x32 Booth multiplier, low word result plus overflow flag
module booth_mult32
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  mult_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;
  logic             step_q1;
  logic [WIDTH:0]   prod_hi;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q_1_i (q1_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q),
    .q_1_o (step_q1)
  );

  // Product bits [63:31]; they must all agree for the result to fit in 32 signed bits.
  assign prod_hi = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    q1_d     = q1_q;
    m_d      = m_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    if (ctrl_MULT) begin
      // A start in any state reloads; an aborted operation never reaches DONE.
      state_d = ST_RUN;
      cnt_d   = '0;
      acc_d   = '0;
      q_d     = data_operandB;
      q1_d    = 1'b0;
      m_d     = {data_operandA[WIDTH-1], data_operandA};
    end else begin
      case (state_q)
        ST_RUN: begin
          acc_d = step_acc;
          q_d   = step_q;
          q1_d  = step_q1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MULT_ITER - 1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d  = ST_IDLE;
          result_d = q_q;
          exc_d    = ~(&prod_hi | ~|prod_hi);
          rdy_d    = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule
